button_press_gen: RTL and testbench

BUTTON_PRESS_GEN -- requirements
Module: button_press_gen

---
 rtl/button_press_gen.sv | 97 +++++++++
 tb/tb_button_press_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_gen.sv
// rtl/button_press_gen.sv - Pushbutton waveform generator for bursts of short/long presses
module button_press_gen #(
    parameter int SHORT_TICKS = 100,
    parameter int LONG_TICKS  = 1500,
    parameter int GAP_TICKS   = 300
) (
    input  logic       clk_1khz_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    input  logic       cmd_long_i,
    input  logic [3:0] cmd_count_i,
    input  logic       abort_i,
    output logic       cmd_ready_o,
    output logic       pushbutton_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] remaining_o
);
    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    // Tick counter is loaded with duration-1 and the state ends when it reaches zero.
    localparam logic [10:0] SHORT_LOAD = 11'(SHORT_TICKS - 1);
    localparam logic [10:0] LONG_LOAD  = 11'(LONG_TICKS - 1);
    localparam logic [10:0] GAP_LOAD   = 11'(GAP_TICKS - 1);

    state_t      state;
    logic [10:0] tick;
    logic        long_q;
    logic [10:0] press_load;

    assign press_load = long_q ? LONG_LOAD : SHORT_LOAD;

    always_ff @(posedge clk_1khz_i) begin
        if (rst_i) begin
            state        <= IDLE;
            tick         <= '0;
            remaining_o  <= '0;
            long_q       <= 1'b0;
            pushbutton_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            cmd_ready_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_ready_o && cmd_valid_i && !abort_i) begin
                        state        <= PRESS;
                        tick         <= cmd_long_i ? LONG_LOAD : SHORT_LOAD;
                        long_q       <= cmd_long_i;
                        remaining_o  <= (cmd_count_i == 4'd0) ? 4'd1 : cmd_count_i;
                        pushbutton_o <= 1'b1;
                        busy_o       <= 1'b1;
                        cmd_ready_o  <= 1'b0;
                    end
                end
                PRESS, GAP: begin
                    if (abort_i) begin
                        state        <= IDLE;
                        tick         <= '0;
                        remaining_o  <= '0;
                        pushbutton_o <= 1'b0;
                        busy_o       <= 1'b0;
                        cmd_ready_o  <= 1'b1;
                    end else if (tick != '0) begin
                        tick <= tick - 11'd1;
                    end else if (state == PRESS) begin
                        state        <= GAP;
                        tick         <= GAP_LOAD;
                        pushbutton_o <= 1'b0;
                        if (remaining_o != 4'd0) begin
                            remaining_o <= remaining_o - 4'd1;
                        end
                    end else if (remaining_o != 4'd0) begin
                        state        <= PRESS;
                        tick         <= press_load;
                        pushbutton_o <= 1'b1;
                    end else begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        done_o      <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    tick         <= '0;
                    remaining_o  <= '0;
                    pushbutton_o <= 1'b0;
                    busy_o       <= 1'b0;
                    cmd_ready_o  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_press_gen.sv
// tb/tb_button_press_gen.sv - Scoreboard bench for button_press_gen with randomized bursts
module tb_button_press_gen;
    localparam int SHORT = 4;
    localparam int LONG  = 10;
    localparam int GAP   = 3;

    typedef struct {
        bit is_done;
        int width;
        int rem;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_long, abort;
    logic [3:0] cmd_count;
    logic       cmd_ready, pb, busy, done;
    logic [3:0] remaining;

    logic       d2_valid, d2_long, d2_abort;
    logic [3:0] d2_count;
    logic       d2_ready, d2_pb, d2_busy, d2_done;
    logic [3:0] d2_rem;

    int  n_checks = 0;
    int  n_pass   = 0;
    ev_t sb[$];

    always #5 clk = ~clk;

    button_press_gen #(.SHORT_TICKS(SHORT), .LONG_TICKS(LONG), .GAP_TICKS(GAP)) dut (
        .clk_1khz_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_long_i(cmd_long),
        .cmd_count_i(cmd_count), .abort_i(abort), .cmd_ready_o(cmd_ready),
        .pushbutton_o(pb), .busy_o(busy), .done_o(done), .remaining_o(remaining)
    );

    button_press_gen dut_default (
        .clk_1khz_i(clk), .rst_i(rst), .cmd_valid_i(d2_valid), .cmd_long_i(d2_long),
        .cmd_count_i(d2_count), .abort_i(d2_abort), .cmd_ready_o(d2_ready),
        .pushbutton_o(d2_pb), .busy_o(d2_busy), .done_o(d2_done), .remaining_o(d2_rem)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: measures each high run and gap of the generated level and pops the scoreboard.
    int  run = 0, start_rem = 0, gap_cnt = 0;
    bit  rem_ok = 1'b1, prev_pb = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (pb && !prev_pb) begin
            if (gap_cnt != 0) chk("gap_len", gap_cnt, GAP);
            run = 1;
            start_rem = int'(remaining);
            rem_ok = 1'b1;
        end else if (pb) begin
            run++;
            if (int'(remaining) != start_rem) rem_ok = 1'b0;
        end
        if (!pb && prev_pb) begin
            chk("press_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("press_not_done", int'(e.is_done), 0);
                chk("press_width", run, e.width);
                chk("press_remaining", start_rem, e.rem);
                chk("remaining_stable", int'(rem_ok), 1);
            end
        end
        if (done) begin
            chk("last_gap_len", gap_cnt, GAP);
            chk("done_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("done_kind", int'(e.is_done), 1);
            end
        end
        gap_cnt = (busy && !pb) ? gap_cnt + 1 : 0;
        prev_pb = pb;
    end

    // Issues one command (caller is in a cycle with cmd_ready high) and steps through the burst.
    // kill: cycle (1-based after handshake) in which abort or reset is driven; 0 = none.
    task automatic run_burst(input bit lng, input int cnt, input int kill, input bit kill_rst,
                             input int stray);
        int  t, n, total, s, w, bc;
        ev_t e;
        t = lng ? LONG : SHORT;
        n = (cnt == 0) ? 1 : cnt;
        total = n * (t + GAP);
        chk("ready_before_cmd", int'(cmd_ready), 1);
        for (int i = 0; i < n; i++) begin
            s = i * (t + GAP) + 1;
            if (kill != 0 && kill < s) break;
            w = (kill != 0 && kill - s + 1 < t) ? kill - s + 1 : t;
            e.is_done = 1'b0; e.width = w; e.rem = n - i;
            sb.push_back(e);
        end
        if (kill == 0) begin
            e.is_done = 1'b1; e.width = 0; e.rem = 0;
            sb.push_back(e);
        end
        cmd_valid = 1'b1; cmd_long = lng; cmd_count = 4'(cnt);
        step();
        cmd_valid = 1'b0;
        bc = 0;
        for (int c = 1; c <= total; c++) begin
            if (c == 1) begin
                chk("press_starts_next_cycle", int'(pb), 1);
                chk("remaining_at_start", int'(remaining), n);
            end
            if (busy) bc++;
            if (c == stray) begin
                cmd_valid = 1'b1; cmd_long = 1'($urandom); cmd_count = 4'($urandom);
            end
            if (c == kill) begin
                if (kill_rst) rst = 1'b1;
                else abort = 1'b1;
            end
            step();
            cmd_valid = 1'b0; abort = 1'b0; rst = 1'b0;
            if (c == kill) break;
        end
        if (kill == 0) begin
            chk("busy_cycles", bc, total);
            chk("done_pulse", int'(done), 1);
            chk("ready_in_done_cycle", int'(cmd_ready), 1);
        end else begin
            chk("kill_pb_low", int'(pb), 0);
            chk("kill_busy_low", int'(busy), 0);
            chk("kill_done_low", int'(done), 0);
            chk("kill_remaining_zero", int'(remaining), 0);
            chk("kill_ready", int'(cmd_ready), kill_rst ? 0 : 1);
            if (kill_rst) begin
                step();
                chk("ready_after_reset", int'(cmd_ready), 1);
            end
        end
    endtask

    // Default-parameter instance: issues one command and measures every press it produces.
    int d2_presses = 0;
    task automatic d2_cmd(input bit lng, input int cnt);
        int n, t, w, r;
        n = (cnt == 0) ? 1 : cnt;
        t = 0;
        while (!d2_ready && t < 1000) begin step(); t++; end
        chk("d2_ready", int'(d2_ready), 1);
        d2_valid = 1'b1; d2_long = lng; d2_count = 4'(cnt);
        step();
        d2_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!d2_pb && t < 1000) begin step(); t++; end
            r = int'(d2_rem);
            w = 0;
            while (d2_pb && w < 3000) begin step(); w++; end
            chk("d2_width", w, lng ? 1500 : 100);
            chk("d2_remaining", r, n - k);
            d2_presses++;
        end
        t = 0;
        while (!d2_done && t < 1000) begin step(); t++; end
        chk("d2_done", int'(d2_done), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lng;
        int cnt, n, total, kill, stray;
        rst = 1'b1; cmd_valid = 1'b0; cmd_long = 1'b0; cmd_count = 4'd0; abort = 1'b0;
        d2_valid = 1'b0; d2_long = 1'b0; d2_count = 4'd0; d2_abort = 1'b0;
        step(); step();
        chk("reset_pb", int'(pb), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ready", int'(cmd_ready), 0);
        chk("reset_remaining", int'(remaining), 0);
        rst = 1'b0;
        step();
        chk("ready_first_cycle_after_reset", int'(cmd_ready), 1);

        cmd_valid = 1'b1; abort = 1'b1; cmd_long = 1'b1; cmd_count = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_blocks_accept", int'(busy), 0);
        end
        cmd_valid = 1'b0; abort = 1'b0;
        step();

        run_burst(1'b0, 1, 0, 1'b0, 0);           // single short press
        step(); step();
        run_burst(1'b1, 3, 0, 1'b0, 7);           // long burst of 3, stray command mid-burst
        run_burst(1'b0, 0, 0, 1'b0, 0);           // count 0, back-to-back in done cycle
        run_burst(1'b1, 3, LONG + GAP + 5, 1'b0, 0);  // abort in 5th cycle of 2nd press
        run_burst(1'b0, 2, 6, 1'b1, 0);           // reset during first gap
        run_burst(1'b1, 15, 0, 1'b0, 100);        // full 15-press burst

        for (int i = 0; i < 25; i++) begin
            lng = 1'($urandom_range(0, 1));
            cnt = $urandom_range(0, 15);
            n = (cnt == 0) ? 1 : cnt;
            total = n * ((lng ? LONG : SHORT) + GAP);
            kill = ($urandom_range(0, 3) == 0) ? $urandom_range(1, total) : 0;
            stray = $urandom_range(1, total);
            run_burst(lng, cnt, kill, 1'($urandom_range(0, 4) == 0), stray);
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < $urandom_range(1, 3); j++) step();
            end
        end
        step(); step();
        chk("scoreboard_empty", sb.size(), 0);

        for (int i = 0; i < 3; i++) d2_cmd(1'b0, 1);
        chk("d2_short_press_count", d2_presses, 3);
        d2_cmd(1'b1, 2);
        chk("d2_total_press_count", d2_presses, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
